// File: rtl/pattern_playback_ctrl_pkg.sv
// Shared definitions for the pattern-game playback sequencer.
//   state_e          : sequencer states with fixed encodings (IDLE=0, GAP=1, SHOW=2, DONE=3)
//   MAX_LEN_DEFAULT  : default maximum number of playable symbols
//   sym_to_led()     : 2-bit symbol to one-hot 4-LED drive
//   clamp_len()      : limits a requested length to the playable maximum
package pattern_playback_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned MAX_LEN_DEFAULT = 11;

    function automatic logic [3:0] sym_to_led(input logic [1:0] sym);
        return 4'b0001 << sym;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step timer for the playback sequencer.
// Counts clocks within one GAP or SHOW phase and pulses o_tc on the last clock
// of the phase (count == CLKS_PER_STEP-1). i_clear forces the count back to 0
// so that every state entry starts a full-length phase.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : synchronous reload to 0 (takes priority over counting)
//   o_tc     : terminal-count indication, high for one clock per phase
module step_timer #(
    parameter int unsigned CLKS_PER_STEP = 6250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tc
);

    localparam int unsigned CNT_W = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLKS_PER_STEP - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tc = (cnt_q == TC_VAL);

    // Wrapping on terminal count keeps the counter in range even if a phase
    // were ever held without a clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clear || o_tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_playback_ctrl.sv
// Pattern playback sequencer for the 4-LED pattern-game bank.
// On an accepted start it plays the first len symbols of the pattern store as
// alternating dark GAP and lit SHOW phases of CLKS_PER_STEP clocks each, then
// pulses o_done for one clock. While idle the LEDs echo the live switches.
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_start     : 1-cycle playback request, honoured only in IDLE
//   i_abort     : synchronous abort back to IDLE, no o_done
//   i_length    : requested symbol count, clamped to MAX_LEN
//   o_rd_index  : pattern-store read index (current symbol)
//   i_rd_sym    : pattern-store data for o_rd_index (same cycle)
//   i_switch    : debounced switch levels
//   o_led       : registered LED drive
//   o_busy      : high in GAP, SHOW and DONE
//   o_done      : 1-cycle pulse on normal completion
module pattern_playback_ctrl
    import pattern_playback_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_STEP = 6250000,
    parameter int unsigned MAX_LEN       = MAX_LEN_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [3:0] i_length,
    output logic [3:0] o_rd_index,
    input  logic [1:0] i_rd_sym,
    input  logic [3:0] i_switch,
    output logic [3:0] o_led,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_e     state_q, state_d;
    logic [3:0] index_q, index_d;
    logic [3:0] len_q,   len_d;
    logic [3:0] led_q,   led_d;
    logic       step_tc;
    logic       timer_clear;
    logic [3:0] len_req;

    step_timer #(
        .CLKS_PER_STEP(CLKS_PER_STEP)
    ) u_step_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (timer_clear),
        .o_tc    (step_tc)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        len_d       = len_q;
        led_d       = led_q;
        len_req     = clamp_len(i_length, MAX_LEN_L);

        case (state_q)
            ST_IDLE: begin
                led_d = i_switch;
                if (i_start) begin
                    len_d   = len_req;
                    index_d = '0;
                    state_d = (len_req == 4'd0) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                led_d = '0;
                if (step_tc) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                led_d = sym_to_led(i_rd_sym);
                if (step_tc) begin
                    if (index_q == (len_q - 4'd1)) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_DONE: begin
                led_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                led_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any start or terminal-count decision made above;
        // the index is left where it was rather than advanced.
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            index_d = index_q;
        end

        // Reload the timer on every state change and hold it at 0 while idle,
        // so each GAP/SHOW phase gets the full CLKS_PER_STEP clocks.
        timer_clear = (state_d != state_q) || (state_q == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            len_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            led_q   <= led_d;
        end
    end

    assign o_led      = led_q;
    assign o_rd_index = index_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule
